axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI4 slave (responder) backed by an on-chip byte-strobed memory array; the other end of the core's membus-to-AXI master.
- Lets the CPU core and top-level run in simulation or on-fabric without DRAM or the PS.
- Used as a boot/scratch RAM.
- Independent read and write engines, one outstanding transaction per direction, INCR/FIXED bursts.

Parameters:
- AXI_ID_W, 1, width of AWID/BID/ARID/RID
- AXI_ADDR_W, 32, address width
- AXI_DATA_W, 64, data width; the only legal transfer size is log2(AXI_DATA_W/8)
- MEM_BYTES, 65536, array size in bytes; power of two, multiple of AXI_DATA_W/8
- BASE_ADDR, 32'h0000_0000, first decoded byte address; aligned to MEM_BYTES

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  AXI_ID_W/AXI_ADDR_W/8/3/2  write address
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
- S_AXI_WDATA/WSTRB/WLAST  in  AXI_DATA_W/AXI_DATA_W/8/1  write data
- S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BID/BRESP  out  AXI_ID_W/2  write response
- S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  AXI_ID_W/AXI_ADDR_W/8/3/2  read address
- S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
- S_AXI_RID/RDATA/RRESP/RLAST  out  AXI_ID_W/AXI_DATA_W/2/1  read data
- S_AXI_RVALID out 1; S_AXI_RREADY in 1

Behaviour:
- Clocking and reset: single clock domain ACLK. ARESETN is asynchronous and active-low.
- Reset state:
  - AWREADY=1, ARREADY=1
  - WREADY=0, BVALID=0, RVALID=0, RLAST=0
  - BRESP/RRESP/RDATA/BID/RID=0
  - Both FSMs in IDLE
  - Array contents are not reset.
- Write FSM:
  - W_IDLE (AWREADY=1): on AW handshake, latch ID, beat address = AWADDR aligned down to the bus width, len, burst; clear err; go to W_DATA.
  - W_DATA (WREADY=1): each W handshake writes the bytes enabled by WSTRB at the beat address.
    - INCR: address += AXI_DATA_W/8 after each beat. FIXED: address holds.
    - The beat counter increments per beat.
    - On the beat with WLAST=1, go to W_RESP.
  - W_RESP (BVALID=1, BID=latched ID): hold BRESP/BID stable until BREADY. The cycle after the B handshake, enter W_IDLE with AWREADY=1.
- Write error rules (one sticky error per burst; DECERR takes precedence over SLVERR):
  - Beat address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES): that beat's write is dropped; BRESP=DECERR.
  - AWSIZE≠native size or AWBURST=WRAP/reserved: all beats dropped; BRESP=SLVERR.
  - WLAST on a beat other than AWLEN+1: SLVERR, burst ends at WLAST.
  - No WLAST at beat AWLEN+1: SLVERR, keep accepting beats until WLAST; beats past AWLEN+1 are dropped.
- Read FSM:
  - R_IDLE (ARREADY=1): on AR handshake at cycle N, the first beat is presented with RVALID=1 at cycle N+1.
  - R_DATA: RDATA/RRESP/RLAST/RID are registered and held stable while RVALID=1 and RREADY=0.
  - On each R handshake:
    - If it is not the last beat, the next beat is valid the following cycle (no bubble needed; one bubble per beat is allowed only when the optional feature is enabled).
    - RLAST=1 on beat ARLEN+1. After its handshake, return to R_IDLE (ARREADY=1 the next cycle).
- Read error rules:
  - Out-of-range beat: RDATA=0, RRESP=DECERR for that beat only.
  - Bad size or burst type: every beat RDATA=0, RRESP=SLVERR. The full ARLEN+1 beats are still returned.
- Read/write interaction: the engines run concurrently. A read of an address written in the same cycle returns the old data.
- Address wrap: beat addresses increment modulo 2^AXI_ADDR_W. A burst crossing the top of the window yields DECERR on the out-of-range beats only.
- Reset mid-burst: all handshake outputs return to reset values asynchronously. Partially written beats remain in the array.

Optional Feature:
- Macro: AXI_SRAM_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - AWREADY, WREADY and ARREADY are forced to 0 in cycles where lfsr[0]=0.
  - Assertion of a new RVALID or BVALID is delayed while lfsr[1]=0.
  - Once asserted, VALID never drops before its handshake.
- Undefined: no LFSR; ready and valid timing exactly as in Behaviour.

Test Plan:
- Write, strobe merge, read back: AW addr 0x10, len 0, WDATA 64'h1122334455667788, WSTRB 8'h0F; then WDATA 64'hFFFF_FFFF_FFFF_FFFF, WSTRB 8'hF0; read 0x10 -> RDATA 64'hFFFFFFFF55667788, RRESP OKAY, RLAST=1, RVALID the cycle after the AR handshake.
- 4-beat INCR at 0x100 with data 1,2,3,4 -> BRESP OKAY. 4-beat INCR read -> beats 1,2,3,4, RLAST only on the 4th. FIXED read at 0x100 -> 1,1,1,1.
- Out-of-range: write addr BASE_ADDR+MEM_BYTES -> BRESP DECERR, array unchanged. Read 2-beat at BASE_ADDR+MEM_BYTES-8 -> beat0 OKAY with data, beat1 DECERR with data 0.
- WLAST protocol error: AWLEN=3, WLAST on the 2nd beat -> BRESP SLVERR, BVALID follows; a subsequent AW is accepted.
- Backpressure: RREADY held 0 for 5 cycles mid-burst -> RDATA/RLAST/RID stable. BREADY held 0 -> BVALID/BRESP stable, AWREADY stays 0.
- Reset: ARESETN low during beat 2 of a 4-beat read -> RVALID=0 immediately, ARREADY=1 after release; a new read completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a byte-strobed on-chip RAM; independent single-outstanding read/write engines.
// Optional random ready/valid throttling when AXI_SRAM_BACKPRESSURE_EN is defined.
module axi_sram_slave #(
  parameter int                    AXI_ID_W   = 1,
  parameter int                    AXI_ADDR_W = 32,
  parameter int                    AXI_DATA_W = 64,
  parameter int                    MEM_BYTES  = 65536,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [AXI_ID_W-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [AXI_DATA_W-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [AXI_ID_W-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [AXI_ID_W-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [AXI_ID_W-1:0]     S_AXI_RID,
  output logic [AXI_DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);
  localparam int STRB_W     = AXI_DATA_W / 8;
  localparam int BYTE_OFF_W = $clog2(STRB_W);
  localparam int MEM_WORDS  = MEM_BYTES / STRB_W;
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam logic [2:0]            NATIVE_SIZE = 3'(BYTE_OFF_W);
  localparam logic [AXI_ADDR_W-1:0] BEAT_INC    = AXI_ADDR_W'(STRB_W);
  localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK  = ~(AXI_ADDR_W'(STRB_W - 1));
  localparam logic [AXI_ADDR_W-1:0] WIN_SIZE    = AXI_ADDR_W'(MEM_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic in_window(input logic [AXI_ADDR_W-1:0] addr);
    return (addr - BASE_ADDR) < WIN_SIZE;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> BYTE_OFF_W);
  endfunction

  logic ready_gate_s, valid_gate_s;
`ifdef AXI_SRAM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  // Free-running Fibonacci LFSR (taps 16,14,13,11) that throttles ready/valid
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lfsr_q <= 16'hACE1;
    else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign ready_gate_s = lfsr_q[0];
  assign valid_gate_s = lfsr_q[1];
`else
  assign ready_gate_s = 1'b1;
  assign valid_gate_s = 1'b1;
`endif

  logic [AXI_DATA_W-1:0] mem_q [MEM_WORDS];

  // ---------------- write engine ----------------
  w_state_e              w_state_q, w_state_d;
  logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
  logic [AXI_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [8:0]            w_cnt_q, w_cnt_d;
  logic                  w_fixed_q, w_fixed_d, w_bad_q, w_bad_d;
  logic                  w_dec_q, w_dec_d, w_slv_q, w_slv_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;
  logic                  aw_hs_s, w_hs_s, beat_dec_s, beyond_s, last_idx_s, mem_we_s;

  assign S_AXI_AWREADY = (w_state_q == W_IDLE) & ready_gate_s;
  assign S_AXI_WREADY  = (w_state_q == W_DATA) & ready_gate_s;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = w_id_q;
  assign aw_hs_s       = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs_s        = S_AXI_WVALID & S_AXI_WREADY;
  assign beat_dec_s    = ~in_window(w_addr_q);
  assign beyond_s      = w_cnt_q > {1'b0, w_len_q};
  assign last_idx_s    = w_cnt_q == {1'b0, w_len_q};

  // Write FSM next-state and sticky error tracking
  always_comb begin
    w_state_d = w_state_q;  w_id_d  = w_id_q;  w_addr_d = w_addr_q;  w_len_d = w_len_q;
    w_cnt_d   = w_cnt_q;    w_fixed_d = w_fixed_q;  w_bad_d = w_bad_q;
    w_dec_d   = w_dec_q;    w_slv_d = w_slv_q;  bresp_d = bresp_q;  bvalid_d = bvalid_q;
    mem_we_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_id_d    = S_AXI_AWID;
          w_addr_d  = S_AXI_AWADDR & ALIGN_MASK;
          w_len_d   = S_AXI_AWLEN;
          w_cnt_d   = 9'd0;
          w_fixed_d = (S_AXI_AWBURST == 2'b00);
          w_bad_d   = (S_AXI_AWSIZE != NATIVE_SIZE) | S_AXI_AWBURST[1];
          w_dec_d   = 1'b0;
          w_slv_d   = 1'b0;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          // Beats past the announced length are swallowed but not written
          mem_we_s = ~beat_dec_s & ~w_bad_q & ~beyond_s;
          w_dec_d  = w_dec_q | (beat_dec_s & ~beyond_s);
          w_slv_d  = w_slv_q | w_bad_q | (S_AXI_WLAST != last_idx_s);
          if (!w_fixed_q) w_addr_d = w_addr_q + BEAT_INC;
          else            w_addr_d = w_addr_q;
          if (w_cnt_q != 9'h1FF) w_cnt_d = w_cnt_q + 9'd1;
          else                   w_cnt_d = w_cnt_q;
          if (S_AXI_WLAST) begin
            bresp_d   = w_dec_d ? RESP_DECERR : (w_slv_d ? RESP_SLVERR : RESP_OKAY);
            bvalid_d  = valid_gate_s;
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (!bvalid_q) begin
          bvalid_d = valid_gate_s;
        end else if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;  w_id_q <= '0;  w_addr_q <= '0;  w_len_q <= 8'd0;  w_cnt_q <= 9'd0;
      w_fixed_q <= 1'b0;  w_bad_q <= 1'b0;  w_dec_q <= 1'b0;  w_slv_q <= 1'b0;
      bresp_q   <= 2'b00;  bvalid_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;  w_id_q <= w_id_d;  w_addr_q <= w_addr_d;  w_len_q <= w_len_d;
      w_cnt_q   <= w_cnt_d;  w_fixed_q <= w_fixed_d;  w_bad_q <= w_bad_d;  w_dec_q <= w_dec_d;
      w_slv_q   <= w_slv_d;  bresp_q <= bresp_d;  bvalid_q <= bvalid_d;
    end
  end

  // Byte-strobed array write; contents intentionally survive reset
  always_ff @(posedge ACLK) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (mem_we_s && S_AXI_WSTRB[b]) mem_q[word_idx(w_addr_q)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
    end
  end

  // ---------------- read engine ----------------
  r_state_e              r_state_q, r_state_d;
  logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
  logic [AXI_ADDR_W-1:0] r_addr_q, r_addr_d, rd_addr_s;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                  r_fixed_q, r_fixed_d, r_bad_q, r_bad_d, rd_bad_s, rd_load_s;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [1:0]            rresp_q;

  assign S_AXI_ARREADY = (r_state_q == R_IDLE) & ready_gate_s;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RID     = r_id_q;

  // Read FSM: selects which beat address the data register loads next
  always_comb begin
    r_state_d = r_state_q;  r_id_d = r_id_q;  r_addr_d = r_addr_q;  r_len_d = r_len_q;
    r_cnt_d   = r_cnt_q;  r_fixed_d = r_fixed_q;  r_bad_d = r_bad_q;
    rvalid_d  = rvalid_q;  rlast_d = rlast_q;
    rd_load_s = 1'b0;  rd_addr_s = r_addr_q;  rd_bad_s = r_bad_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          r_id_d    = S_AXI_ARID;
          r_addr_d  = S_AXI_ARADDR & ALIGN_MASK;
          r_len_d   = S_AXI_ARLEN;
          r_cnt_d   = 8'd0;
          r_fixed_d = (S_AXI_ARBURST == 2'b00);
          r_bad_d   = (S_AXI_ARSIZE != NATIVE_SIZE) | S_AXI_ARBURST[1];
          rd_bad_s  = r_bad_d;
          rd_addr_s = r_addr_d;
          rd_load_s = 1'b1;
          rlast_d   = (S_AXI_ARLEN == 8'd0);
          rvalid_d  = valid_gate_s;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (!rvalid_q) begin
          rvalid_d = valid_gate_s;
        end else if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_fixed_q ? r_addr_q : r_addr_q + BEAT_INC;
            r_cnt_d   = r_cnt_q + 8'd1;
            rd_addr_s = r_addr_d;
            rd_load_s = 1'b1;
            rlast_d   = (r_cnt_d == r_len_q);
            rvalid_d  = valid_gate_s;
          end
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read engine registers, including the registered beat data/response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;  r_id_q <= '0;  r_addr_q <= '0;  r_len_q <= 8'd0;  r_cnt_q <= 8'd0;
      r_fixed_q <= 1'b0;  r_bad_q <= 1'b0;  rvalid_q <= 1'b0;  rlast_q <= 1'b0;
      rdata_q   <= '0;  rresp_q <= 2'b00;
    end else begin
      r_state_q <= r_state_d;  r_id_q <= r_id_d;  r_addr_q <= r_addr_d;  r_len_q <= r_len_d;
      r_cnt_q   <= r_cnt_d;  r_fixed_q <= r_fixed_d;  r_bad_q <= r_bad_d;
      rvalid_q  <= rvalid_d;  rlast_q <= rlast_d;
      if (rd_load_s) begin
        if (!in_window(rd_addr_s)) begin
          rdata_q <= '0;
          rresp_q <= RESP_DECERR;
        end else if (rd_bad_s) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end else begin
          rdata_q <= mem_q[word_idx(rd_addr_s)];
          rresp_q <= RESP_OKAY;
        end
      end else begin
        rdata_q <= rdata_q;
        rresp_q <= rresp_q;
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed scoreboard bench for axi_sram_slave: expectations queued at stimulus time, checked on B/R.
module tb_axi_sram_slave;
  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic [0:0]  awid = 1'b0, bid, arid = 1'b0, rid;
  logic [31:0] awaddr = 32'h0, araddr = 32'h0;
  logic [7:0]  awlen = 8'h0, arlen = 8'h0;
  logic [2:0]  awsize = 3'd3, arsize = 3'd3;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready, rvalid, rready = 1'b0, rlast;
  logic [63:0] wdata = 64'h0, rdata;
  logic [7:0]  wstrb = 8'h0;

  int vectors = 0, miscompares = 0;
  logic [63:0] exp_rdata_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic        exp_rlast_q[$];
  logic [1:0]  exp_bresp_q[$];

  always #5 ACLK = ~ACLK;

  axi_sram_slave #(.AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(64), .MEM_BYTES(65536),
                   .BASE_ADDR(32'h0000_0000)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_r(input logic [63:0] d, input logic [1:0] r, input logic l);
    exp_rdata_q.push_back(d);
    exp_rresp_q.push_back(r);
    exp_rlast_q.push_back(l);
  endtask

  // All tasks are entered and left just after a falling edge.
  task automatic send_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic id);
    int n = 0;
    awaddr = a; awlen = l; awburst = b; awsize = 3'd3; awid = id; awvalid = 1'b1;
    while (!awready && n < 100) begin @(negedge ACLK); n++; end
    if (n >= 100) chk("aw_timeout", 64'd0, 64'd1);
    @(negedge ACLK); awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 100) begin @(negedge ACLK); n++; end
    if (n >= 100) chk("w_timeout", 64'd0, 64'd1);
    @(negedge ACLK); wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic recv_b(input logic id);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 100) begin @(negedge ACLK); n++; end
    if (n >= 100 || exp_bresp_q.size() == 0) chk("b_timeout", 64'd0, 64'd1);
    else begin
      chk("bresp", 64'(bresp), 64'(exp_bresp_q.pop_front()));
      chk("bid", 64'(bid), 64'(id));
    end
    @(negedge ACLK); bready = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [2:0] sz, input logic id);
    int n = 0;
    araddr = a; arlen = l; arburst = b; arsize = sz; arid = id; arvalid = 1'b1;
    while (!arready && n < 100) begin @(negedge ACLK); n++; end
    if (n >= 100) chk("ar_timeout", 64'd0, 64'd1);
    @(negedge ACLK); arvalid = 1'b0;
  endtask

  task automatic recv_r(input int beats, input logic id);
    rready = 1'b1;
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      while (!rvalid && n < 100) begin @(negedge ACLK); n++; end
      if (n >= 100 || exp_rdata_q.size() == 0) chk("r_timeout", 64'd0, 64'd1);
      else begin
        chk("rdata", rdata, exp_rdata_q.pop_front());
        chk("rresp", 64'(rresp), 64'(exp_rresp_q.pop_front()));
        chk("rlast", 64'(rlast), 64'(exp_rlast_q.pop_front()));
        chk("rid", 64'(rid), 64'(id));
      end
      @(negedge ACLK);
    end
    rready = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_resps", {60'd0, bresp, rresp}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_ids", {62'd0, bid, rid}, 64'd0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // strobe merge at 0x10
    send_aw(32'h10, 8'd0, 2'b01, 1'b0); send_w(64'h1122334455667788, 8'h0F, 1'b1);
    exp_bresp_q.push_back(2'b00); recv_b(1'b0);
    send_aw(32'h10, 8'd0, 2'b01, 1'b0); send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1'b1);
    exp_bresp_q.push_back(2'b00); recv_b(1'b0);
    exp_r(64'hFFFFFFFF55667788, 2'b00, 1'b1);
    send_ar(32'h10, 8'd0, 2'b01, 3'd3, 1'b0);
    chk("rvalid_latency", 64'(rvalid), 64'd1);
    recv_r(1, 1'b0);

    // 4-beat INCR write, INCR and FIXED reads
    send_aw(32'h100, 8'd3, 2'b01, 1'b0);
    for (int i = 1; i <= 4; i++) send_w(64'(i), 8'hFF, i == 4);
    exp_bresp_q.push_back(2'b00); recv_b(1'b0);
    for (int i = 1; i <= 4; i++) exp_r(64'(i), 2'b00, i == 4);
    send_ar(32'h100, 8'd3, 2'b01, 3'd3, 1'b0); recv_r(4, 1'b0);
    for (int i = 1; i <= 4; i++) exp_r(64'd1, 2'b00, i == 4);
    send_ar(32'h100, 8'd3, 2'b00, 3'd3, 1'b0); recv_r(4, 1'b0);

    // out-of-range write must not alias into the array
    send_aw(32'h0, 8'd0, 2'b01, 1'b0); send_w(64'hA5A5A5A5A5A5A5A5, 8'hFF, 1'b1);
    exp_bresp_q.push_back(2'b00); recv_b(1'b0);
    send_aw(32'h10000, 8'd0, 2'b01, 1'b0); send_w(64'h0, 8'hFF, 1'b1);
    exp_bresp_q.push_back(2'b11); recv_b(1'b0);
    exp_r(64'hA5A5A5A5A5A5A5A5, 2'b00, 1'b1);
    send_ar(32'h0, 8'd0, 2'b01, 3'd3, 1'b0); recv_r(1, 1'b0);
    send_aw(32'hFFF8, 8'd0, 2'b01, 1'b0); send_w(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
    exp_bresp_q.push_back(2'b00); recv_b(1'b0);
    exp_r(64'hDEADBEEFCAFEF00D, 2'b00, 1'b0); exp_r(64'h0, 2'b11, 1'b1);
    send_ar(32'hFFF8, 8'd1, 2'b01, 3'd3, 1'b0); recv_r(2, 1'b0);

    // early WLAST, then a fresh AW is accepted
    send_aw(32'h200, 8'd3, 2'b01, 1'b0);
    send_w(64'h55, 8'hFF, 1'b0); send_w(64'h66, 8'hFF, 1'b1);
    exp_bresp_q.push_back(2'b10); recv_b(1'b0);
    send_aw(32'h208, 8'd0, 2'b01, 1'b1); send_w(64'h77, 8'hFF, 1'b1);
    exp_bresp_q.push_back(2'b00); recv_b(1'b1);

    // unsupported size: full burst of zeroed SLVERR beats
    exp_r(64'h0, 2'b10, 1'b0); exp_r(64'h0, 2'b10, 1'b1);
    send_ar(32'h100, 8'd1, 2'b01, 3'd2, 1'b0); recv_r(2, 1'b0);

    // R backpressure mid-burst
    for (int i = 1; i <= 4; i++) exp_r(64'(i), 2'b00, i == 4);
    send_ar(32'h100, 8'd3, 2'b01, 3'd3, 1'b1); recv_r(1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", 64'(rvalid), 64'd1);
      chk("stall_rdata", rdata, exp_rdata_q[0]);
      chk("stall_rlast", 64'(rlast), 64'(exp_rlast_q[0]));
      chk("stall_rid", 64'(rid), 64'd1);
      @(negedge ACLK);
    end
    recv_r(3, 1'b1);

    // B backpressure
    send_aw(32'h300, 8'd0, 2'b01, 1'b1); send_w(64'h99, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid", 64'(bvalid), 64'd1);
      chk("bstall_bresp", 64'(bresp), 64'd0);
      chk("bstall_bid", 64'(bid), 64'd1);
      chk("bstall_awready", 64'(awready), 64'd0);
      @(negedge ACLK);
    end
    exp_bresp_q.push_back(2'b00); recv_b(1'b1);
    chk("awready_after_b", 64'(awready), 64'd1);

    // reset during beat 2 of a 4-beat read
    send_ar(32'h100, 8'd3, 2'b01, 3'd3, 1'b0);
    rready = 1'b1;
    @(negedge ACLK);
    chk("pre_rst_beat2", rdata, 64'd2);
    ARESETN = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mid_arready", 64'(arready), 64'd1);
    rready = 1'b0;
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_rst_arready", 64'(arready), 64'd1);
    exp_r(64'hFFFFFFFF55667788, 2'b00, 1'b1);
    send_ar(32'h10, 8'd0, 2'b01, 3'd3, 1'b0); recv_r(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
